ws2812b_tx_ctrl: RTL and testbench

Sequencer for one WS2812B LED chain: accepts 24-bit pixels from the frame source over a valid/ready stream and drives the load/shift/valid strobes of the 24-bit pixel shift buffer. Consumes the buffer's serial bit and transmit-enable outputs and encodes them into the single-wire WS2812B waveform (T0H/T1H high times, fixed bit period, reset/latch gap at end of frame). Sits between the pixel source and the buffer on the `scl` domain; the buffer's inputs are driven only by this block.

---
 rtl/ws2812b_tx_ctrl.sv | 151 +++++++++++++++
 tb/tb_ws2812b_tx_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_tx_ctrl.sv
// WS2812B chain sequencer: pulls 24-bit GRB pixels from a valid/ready stream,
// drives the pixel shift buffer strobes and encodes its serial bit onto dout.
module ws2812b_tx_ctrl #(
  parameter int T_BIT   = 50,
  parameter int T0H     = 16,
  parameter int T1H     = 32,
  parameter int T_RESET = 2400
) (
  input  logic        scl,
  input  logic        reset_n,
  input  logic [23:0] pixel_data,
  input  logic        pixel_valid,
  input  logic        pixel_last,
  output logic        pixel_ready,
  output logic [23:0] buf_data,
  output logic        buf_load,
  output logic        buf_shift,
  output logic        buf_valid,
  input  logic        buf_data_out,
  input  logic        buf_tx_en,
  output logic        dout,
  output logic        busy,
  output logic        underrun
);

  localparam int PW = $clog2(T_BIT);
  localparam int RW = $clog2(T_RESET + 1);
  localparam logic [PW-1:0] PHASE_END = PW'(T_BIT - 1);
  localparam logic [PW-1:0] T0H_C     = PW'(T0H);
  localparam logic [PW-1:0] T1H_C     = PW'(T1H);
  localparam logic [RW-1:0] LATCH_END = RW'(T_RESET - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BIT   = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] phase, phase_nx;
  logic [4:0]    bit_cnt, bit_cnt_nx;
  logic [RW-1:0] rst_cnt, rst_cnt_nx;
  logic          cur_bit, cur_bit_nx;
  logic          last_r, last_nx;
  logic          underrun_r, underrun_nx;
  logic          dout_r, dout_nx;
  logic          accept;
  logic          tx_bit;

  // Handshake: a pixel transfers on a rising scl edge where pixel_valid and
  // pixel_ready are both high; the source holds data/last stable until then.
  always_comb begin
    state_nx    = state;
    phase_nx    = phase;
    bit_cnt_nx  = bit_cnt;
    rst_cnt_nx  = rst_cnt;
    cur_bit_nx  = cur_bit;
    last_nx     = last_r;
    underrun_nx = underrun_r;
    dout_nx     = 1'b0;
    pixel_ready = 1'b0;
    buf_load    = 1'b0;
    buf_shift   = 1'b0;
    buf_valid   = 1'b0;
    buf_data    = '0;
    accept      = 1'b0;
    tx_bit      = cur_bit;

    case (state)
      ST_IDLE: begin
        pixel_ready = 1'b1;
        accept      = pixel_valid;
      end
      ST_BIT: begin
        // The buffer's bit is only settled at phase 0, so use it directly then.
        if (phase == '0) begin
          tx_bit     = buf_data_out;
          cur_bit_nx = buf_data_out;
        end
        dout_nx = buf_tx_en && (phase < (tx_bit ? T1H_C : T0H_C));
        if (phase != PHASE_END) begin
          phase_nx = phase + 1'b1;
        end else if (bit_cnt != 5'd23) begin
          buf_shift  = 1'b1;
          phase_nx   = '0;
          bit_cnt_nx = bit_cnt + 1'b1;
        end else if (!last_r && pixel_valid) begin
          pixel_ready = 1'b1;
          accept      = 1'b1;
        end else begin
          // Loading an invalid empty word drops the buffer's tx enable.
          buf_load    = 1'b1;
          underrun_nx = underrun_r | ~last_r;
          rst_cnt_nx  = '0;
          state_nx    = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (rst_cnt == LATCH_END) state_nx = ST_IDLE;
        else                      rst_cnt_nx = rst_cnt + 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase

    if (accept) begin
      buf_load    = 1'b1;
      buf_valid   = 1'b1;
      buf_data    = pixel_data;
      last_nx     = pixel_last;
      underrun_nx = 1'b0;
      phase_nx    = '0;
      bit_cnt_nx  = '0;
      state_nx    = ST_BIT;
    end

    if (!reset_n) begin
      pixel_ready = 1'b0;
      buf_load    = 1'b0;
      buf_shift   = 1'b0;
      buf_valid   = 1'b0;
      buf_data    = '0;
    end
  end

  always_ff @(posedge scl) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      phase      <= '0;
      bit_cnt    <= '0;
      rst_cnt    <= '0;
      cur_bit    <= 1'b0;
      last_r     <= 1'b0;
      underrun_r <= 1'b0;
      dout_r     <= 1'b0;
    end else begin
      state      <= state_nx;
      phase      <= phase_nx;
      bit_cnt    <= bit_cnt_nx;
      rst_cnt    <= rst_cnt_nx;
      cur_bit    <= cur_bit_nx;
      last_r     <= last_nx;
      underrun_r <= underrun_nx;
      dout_r     <= dout_nx;
    end
  end

  assign dout     = dout_r;
  assign busy     = (state != ST_IDLE);
  assign underrun = underrun_r;

endmodule

// File: tb/tb_ws2812b_tx_ctrl.sv
// Bench for ws2812b_tx_ctrl: shift-buffer model, per-cycle reference model
// derived from accept times, and literal waveform checks per scenario.
module tb_ws2812b_tx_ctrl;

  localparam int T_BIT   = 50;
  localparam int T0H     = 16;
  localparam int T1H     = 32;
  localparam int T_RESET = 2400;

  // ---------------- clock / reset ----------------
  logic        scl = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] pixel_data = '0;
  logic        pixel_valid = 1'b0;
  logic        pixel_last = 1'b0;
  logic        pixel_ready;
  logic [23:0] buf_data;
  logic        buf_load, buf_shift, buf_valid;
  logic        buf_data_out = 1'b0;
  logic        buf_tx_en = 1'b0;
  logic        dout, busy, underrun;

  always #5 scl = ~scl;

  ws2812b_tx_ctrl #(.T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .T_RESET(T_RESET)) dut (
    .scl(scl), .reset_n(reset_n),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_last(pixel_last),
    .pixel_ready(pixel_ready),
    .buf_data(buf_data), .buf_load(buf_load), .buf_shift(buf_shift), .buf_valid(buf_valid),
    .buf_data_out(buf_data_out), .buf_tx_en(buf_tx_en),
    .dout(dout), .busy(busy), .underrun(underrun)
  );

  // ---------------- pixel shift buffer model ----------------
  logic [23:0] sr = '0;
  logic        sv = 1'b0;
  logic        force_off = 1'b0;

  always @(posedge scl) begin
    if (!reset_n) begin
      sr <= '0;
      sv <= 1'b0;
    end else if (buf_load) begin
      sr <= buf_data;
      sv <= buf_valid;
    end else if (buf_shift) begin
      sr <= {sr[22:0], 1'b0};
    end
  end

  always @(negedge scl) begin
    buf_data_out <= sr[23];
    buf_tx_en    <= sv && !force_off;
  end

  // ---------------- reference model (accept-time arithmetic) ----------------
  int          cyc = 0;
  int          m_mode = 0;       // 0 idle, 1 sending pixel, 2 latch gap
  int          m_start = 0;      // first cycle of the current pixel (A+1)
  int          m_lstart = 0;     // first latch cycle
  logic [23:0] m_data = '0;
  logic        m_last = 1'b0;
  logic        m_und = 1'b0;

  always @(posedge scl) begin
    cyc <= cyc + 1;
    if (!reset_n) begin
      m_mode <= 0;
      m_und  <= 1'b0;
    end else if (m_mode == 0) begin
      if (pixel_valid) begin
        m_mode <= 1; m_data <= pixel_data; m_last <= pixel_last;
        m_und <= 1'b0; m_start <= cyc + 1;
      end
    end else if (m_mode == 1) begin
      if (cyc - m_start == 24 * T_BIT - 1) begin
        if (!m_last && pixel_valid) begin
          m_data <= pixel_data; m_last <= pixel_last;
          m_und <= 1'b0; m_start <= cyc + 1;
        end else begin
          m_mode <= 2; m_lstart <= cyc + 1;
          if (!m_last) m_und <= 1'b1;
        end
      end
    end else begin
      if (cyc - m_lstart == T_RESET - 1) m_mode <= 0;
    end
  end

  function automatic void model_out(output logic e_dout, output logic e_busy,
                                    output logic e_ready, output logic e_load,
                                    output logic e_shift, output logic e_valid,
                                    output logic [23:0] e_data);
    int t, i, p;
    logic b;
    e_dout = 0; e_busy = 0; e_ready = 0; e_load = 0; e_shift = 0; e_valid = 0; e_data = '0;
    if (m_mode == 0) begin
      e_ready = 1'b1;
      e_load  = pixel_valid;
      e_valid = pixel_valid;
      e_data  = pixel_valid ? pixel_data : 24'h0;
    end else if (m_mode == 1) begin
      e_busy = 1'b1;
      t = cyc - m_start;
      i = t / T_BIT;
      p = t % T_BIT;
      b = m_data[23 - i];
      e_dout = !force_off && (p >= 1) && (p <= (b ? T1H : T0H));
      if (p == T_BIT - 1) begin
        if (i < 23) e_shift = 1'b1;
        else if (!m_last && pixel_valid) begin
          e_ready = 1'b1; e_load = 1'b1; e_valid = 1'b1; e_data = pixel_data;
        end else e_load = 1'b1;
      end
    end else begin
      e_busy = 1'b1;
    end
  endfunction

  // ---------------- scoreboard / measurement ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int rises[$];
  int widths[$];
  int run_len = 0;
  logic prev_dout = 1'b0;
  int n_load = 0, n_shift = 0, n_lload = 0;
  int last_acc = 0;
  int ready_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_meas();
    rises.delete(); widths.delete();
    run_len = 0; n_load = 0; n_shift = 0; n_lload = 0;
  endtask

  // One cycle: compare every output against the model, then measure.
  task automatic tick();
    logic e_dout, e_busy, e_ready, e_load, e_shift, e_valid;
    logic [23:0] e_data;
    @(negedge scl);
    if (reset_n) begin
      model_out(e_dout, e_busy, e_ready, e_load, e_shift, e_valid, e_data);
      chk("dout", dout, e_dout);
      chk("busy", busy, e_busy);
      chk("pixel_ready", pixel_ready, e_ready);
      chk("buf_load", buf_load, e_load);
      chk("buf_shift", buf_shift, e_shift);
      if (e_load) chk("buf_valid", buf_valid, e_valid);
      if (e_load) chk("buf_data", buf_data, e_data);
      chk("underrun", underrun, m_und);
      if (buf_load) n_load++;
      if (buf_shift) n_shift++;
      if (buf_load && !buf_valid) n_lload++;
    end
    if (dout && !prev_dout) begin rises.push_back(cyc); run_len = 1; end
    else if (dout) run_len++;
    if (!dout && prev_dout) widths.push_back(run_len);
    prev_dout = dout;
  endtask

  task automatic to_drive();
    @(posedge scl);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin tick(); to_drive(); end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_pixel(input logic [23:0] d, input logic l);
    bit got = 0;
    pixel_data = d; pixel_last = l; pixel_valid = 1'b1;
    for (int k = 0; k < 6000 && !got; k++) begin
      tick();
      if (pixel_ready) begin got = 1; last_acc = cyc; end
    end
    if (!got) chk("accept_timeout", 0, 1);
    to_drive();
    pixel_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int k = 0; k < 10000 && !done; k++) begin
      tick();
      if (!busy && pixel_ready) begin done = 1; ready_cyc = cyc; end
    end
    if (!done) chk("idle_timeout", 0, 1);
    to_drive();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a1, a2, npix;
    int lit[8] = '{32, 16, 32, 16, 16, 32, 16, 32};
    logic lst;

    repeat (3) @(posedge scl);
    #1 reset_n = 1'b1;
    tick();
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", pixel_ready, 1);
    chk("rst_underrun", underrun, 0);
    chk("rst_buf_load", buf_load, 0);
    to_drive();

    // Single pixel 0xA50000, last
    clear_meas();
    send_pixel(24'hA50000, 1'b1);
    a1 = last_acc;
    wait_idle();
    chk("t1_npulse", widths.size(), 24);
    for (int i = 0; i < 24 && i < widths.size(); i++)
      chk($sformatf("t1_width%0d", i), widths[i], (i < 8) ? lit[i] : 16);
    chk("t1_first_rise", rises.size() > 0 ? rises[0] - a1 : -1, 2);
    for (int i = 1; i < rises.size(); i++)
      chk($sformatf("t1_period%0d", i), rises[i] - rises[i-1], T_BIT);
    chk("t1_ready_back", ready_cyc - a1, 1 + 24 * T_BIT + T_RESET);
    chk("t1_loads", n_load, 2);
    chk("t1_shifts", n_shift, 23);
    chk("t1_latch_loads", n_lload, 1);
    cycles(3);

    // Back-to-back 0xFFFFFF then 0x000000
    clear_meas();
    send_pixel(24'hFFFFFF, 1'b0);
    a1 = last_acc;
    send_pixel(24'h000000, 1'b1);
    a2 = last_acc;
    wait_idle();
    chk("t2_accept_gap", a2 - a1, 24 * T_BIT);
    chk("t2_npulse", widths.size(), 48);
    for (int i = 0; i < 48 && i < widths.size(); i++)
      chk($sformatf("t2_width%0d", i), widths[i], (i < 24) ? 32 : 16);
    for (int i = 1; i < rises.size(); i++)
      chk($sformatf("t2_period%0d", i), rises[i] - rises[i-1], T_BIT);
    chk("t2_shifts", n_shift, 46);
    chk("t2_loads", n_load, 3);
    cycles(2);

    // Underrun: last=0 and no follow-up pixel
    clear_meas();
    send_pixel(24'h123456, 1'b0);
    a1 = last_acc;
    wait_idle();
    chk("t3_underrun_set", underrun, 1);
    chk("t3_latch_len", ready_cyc - a1, 1 + 24 * T_BIT + T_RESET);
    send_pixel(24'h00FF00, 1'b1);
    tick();
    chk("t3_underrun_clr", underrun, 0);
    to_drive();
    wait_idle();

    // Reset mid bit 10 of an all-ones pixel
    send_pixel(24'hFFFFFF, 1'b1);
    cycles(10 * T_BIT + 20);
    tick();
    chk("t4_pre_dout", dout, 1);
    to_drive();
    reset_n = 1'b0;
    tick();
    to_drive();
    reset_n = 1'b1;
    tick();
    chk("t4_dout", dout, 0);
    chk("t4_busy", busy, 0);
    chk("t4_ready", pixel_ready, 1);
    to_drive();
    cycles(3);

    // Buffer tx enable held low for a whole frame
    force_off = 1'b1;
    cycles(3);
    clear_meas();
    send_pixel(24'($urandom), 1'b1);
    wait_idle();
    chk("t5_npulse", widths.size() + rises.size(), 0);
    chk("t5_shifts", n_shift, 23);
    chk("t5_loads", n_load, 2);
    force_off = 1'b0;
    cycles(3);

    // Random frames, occasionally ending in an underrun
    for (int f = 0; f < 3; f++) begin
      npix = $urandom_range(1, 2);
      for (int p = 0; p < npix; p++) begin
        lst = (p == npix - 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
        send_pixel(24'($urandom), lst);
      end
      wait_idle();
      cycles($urandom_range(1, 20));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
